// File: rtl/reg_pkg.sv
// Shared definitions for the serial shifter pair (parallel-load TX and SIPO RX).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the output-register state encoding of the receiver and the default
// word width. The parallel-load shifter uses the same width constant so
// both ends of the serial link agree on framing.
package reg_pkg;

  // Default word width shared by transmitter and receiver.
  localparam int SIPO_WIDTH_DEFAULT = 4;

  // One-entry output register state.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sipo_bit_cnt.sv
// Bit position counter for the SIPO receiver; flags the bit that completes a word.
// Latency: cnt is registered; last is combinational from the current strobe and cnt.
// Backpressure: none, counts every strobe regardless of the consumer.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   s_en       - bit strobe
//   sync       - word-boundary marker; realigns the count
//   cnt        - index of the next bit within the word (0..WIDTH-1)
//   last       - high while the strobed bit is the final bit of a word
module sipo_bit_cnt
  import reg_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_en,
  input  logic                     sync,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     last
);

  localparam int CW = $clog2(WIDTH);
  // Explicit terminal count so non-power-of-two widths wrap correctly.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_d;

  // A sync strobe starts a new word, so it can never be the final bit.
  assign last = s_en && !sync && (cnt == CNT_LAST);

  always_comb begin
    cnt_d = cnt;
    if (sync) begin
      // With a strobe the current bit is bit 0, so the next bit is bit 1.
      cnt_d = s_en ? CW'(1) : '0;
    end else if (s_en) begin
      cnt_d = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_sipo_rx.sv
// Serial-in parallel-out receiver with a one-entry valid/ready output register.
// Latency: p_valid rises the cycle after the edge that captures a word's last bit.
// Backpressure: shifting never stalls; a word completing while the held word is
//   unconsumed (p_ready low) is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   s_in, s_en       - serial bit and its capture strobe
//   sync             - word-boundary marker (realigns framing)
//   clr_ovr          - synchronous clear of overrun
//   p_data, p_valid  - completed word and its valid flag
//   p_ready          - consumer accept
//   overrun          - sticky dropped-word flag
module reg_sipo_rx
  import reg_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             sync,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             word_start;

  out_state_e       state_q;
  out_state_e       state_d;
  logic             load;
  logic             ovr_set;

  sipo_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .s_en (s_en),
    .sync (sync),
    .cnt  (cnt),
    .last (last)
  );

  // The first bit of every word restarts the shift register from zero, so
  // leftovers of a discarded partial word never linger in sr.
  assign word_start = s_en && (sync || (cnt == '0));

  always_comb begin
    sr_d = sr;
    if (s_en) begin
      if (MSB_FIRST) begin
        sr_d = word_start ? {{(WIDTH-1){1'b0}}, s_in} : {sr[WIDTH-2:0], s_in};
      end else begin
        sr_d = word_start ? {s_in, {(WIDTH-1){1'b0}}} : {s_in, sr[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= sr_d;
    end
  end

  // Output register: a completion may refill a FULL register in the same
  // edge it is handed off, giving gap-free back-to-back words.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (last) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (last) begin
          if (p_ready) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (p_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      p_data  <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        p_data <= sr_d;
      end
      // A new overrun on the same edge as a clear keeps the flag set.
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign p_valid = (state_q == OUT_FULL);

endmodule

// File: tb/tb_reg_sipo_rx.sv
// Directed bench for reg_sipo_rx: an MSB-first and an LSB-first instance
// share all inputs; each scenario task drives bits and checks outputs one
// time unit after the rising edge.
module tb_reg_sipo_rx;

  logic       clk;
  logic       rst;
  logic       s_in;
  logic       s_en;
  logic       sync;
  logic       clr_ovr;
  logic       p_ready;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  logic [3:0] l_data;
  logic       l_valid;
  logic       l_ovr;

  int checks   = 0;
  int failures = 0;

  reg_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .sync(sync),
    .clr_ovr(clr_ovr), .p_data(m_data), .p_valid(m_valid),
    .p_ready(p_ready), .overrun(m_ovr)
  );

  reg_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .sync(sync),
    .clr_ovr(clr_ovr), .p_data(l_data), .p_valid(l_valid),
    .p_ready(p_ready), .overrun(l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_en = 1'b1;
    s_in = b;
    tick();
    s_en = 1'b0;
    s_in = 1'b0;
  endtask

  task automatic idle();
    s_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_in = 1'b0; s_en = 1'b0; sync = 1'b0; clr_ovr = 1'b0; p_ready = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", m_data); end
    checks++; if (m_ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", m_ovr); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_word();
    p_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", m_valid); end
    send_bit(1'b1);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 4'hB) begin failures++; $display("FAIL basic_data got=%h exp=b", m_data); end
    idle();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", m_valid); end
    checks++; if (m_data !== 4'hB) begin failures++; $display("FAIL basic_data_hold got=%h exp=b", m_data); end
  endtask

  task automatic test_lsb_first();
    p_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++; if (l_valid !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", l_valid); end
    checks++; if (l_data !== 4'hD) begin failures++; $display("FAIL lsb_data got=%h exp=d", l_data); end
    idle();
    checks++; if (l_valid !== 1'b0) begin failures++; $display("FAIL lsb_valid_drop got=%b exp=0", l_valid); end
  endtask

  task automatic test_stall_overrun();
    p_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++; if (m_data !== 4'hA) begin failures++; $display("FAIL stall_first got=%h exp=a", m_data); end
    checks++; if (m_ovr !== 1'b0) begin failures++; $display("FAIL stall_ovr_early got=%b exp=0", m_ovr); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (m_data !== 4'hA) begin failures++; $display("FAIL stall_hold got=%h exp=a", m_data); end
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", m_valid); end
    checks++; if (m_ovr !== 1'b1) begin failures++; $display("FAIL stall_ovr got=%b exp=1", m_ovr); end
    p_ready = 1'b1;
    idle();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stall_consume got=%b exp=0", m_valid); end
    checks++; if (m_ovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", m_ovr); end
    clr_ovr = 1'b1;
    idle();
    clr_ovr = 1'b0;
    checks++; if (m_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", m_ovr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [3];
    logic [3:0] w;
    words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h9;
    p_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      for (int i = 3; i >= 0; i--) begin
        // Accept the held word on the edge that completes the next one.
        p_ready = (k > 0) && (i == 0);
        s_en = 1'b1;
        s_in = w[i];
        tick();
        if (k > 0 || i == 0) begin
          checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid word=%0d bit=%0d got=%b exp=1", k, i, m_valid); end
        end
      end
      checks++; if (m_data !== words[k]) begin failures++; $display("FAIL b2b_data word=%0d got=%h exp=%h", k, m_data, words[k]); end
    end
    s_en = 1'b0;
    checks++; if (m_ovr !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", m_ovr); end
    p_ready = 1'b1;
    idle();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", m_valid); end
  endtask

  task automatic test_realign();
    p_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b0);
    sync = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL realign_early got=%b exp=0", m_valid); end
    send_bit(1'b0);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL realign_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 4'h6) begin failures++; $display("FAIL realign_data got=%h exp=6", m_data); end
    idle();
  endtask

  task automatic test_reset_mid();
    p_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    checks++; if (m_ovr !== 1'b1) begin failures++; $display("FAIL pre_rst_ovr got=%b exp=1", m_ovr); end
    checks++; if (m_data !== 4'hF) begin failures++; $display("FAIL pre_rst_data got=%h exp=f", m_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 4'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", m_data); end
    checks++; if (m_ovr !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%b exp=0", m_ovr); end
    rst = 1'b0;
    p_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", m_valid); end
    checks++; if (m_data !== 4'h7) begin failures++; $display("FAIL post_rst_data got=%h exp=7", m_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_lsb_first();
    test_stall_overrun();
    test_back_to_back();
    test_realign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_sipo_rx.md
# reg_sipo_rx

Serial-in, parallel-out receiver: the receive-side counterpart of the team's 4-bit parallel-load serial shifter. It collects `WIDTH` bits from a serial line under a bit strobe, in MSB-first order by default. It presents each completed word on a one-entry valid/ready output register, so shifting continues while the consumer stalls. Overruns are flagged sticky, and a `sync` input realigns word boundaries.

## Interface
- `WIDTH`, default 4: word length in bits; legal range is 2 or more.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `p_data[WIDTH-1]`; 0 means it lands in `p_data[0]`.

Ports:
- `clk`  input  1  — single clock; all state updates on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `s_in`  input  1  — serial data bit; sampled only when `s_en`=1.
- `s_en`  input  1  — bit strobe; one bit is captured per cycle in which it is high.
- `sync`  input  1  — word-boundary marker (see Operation).
- `clr_ovr`  input  1  — synchronous clear of `overrun`.
- `p_data`  output  WIDTH  — received word; stable while `p_valid`=1.
- `p_valid`  output  1  — output register holds an unconsumed word.
- `p_ready`  input  1  — consumer accepts the word on an edge where `p_valid`&&`p_ready`.
- `overrun`  output  1  — sticky: a completed word was dropped.

## Operation
- **State.** The block holds:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1, width `$clog2(WIDTH)`;
  - output state, either EMPTY (`p_valid`=0) or FULL (`p_valid`=1).
- **Capture.** On an edge with `s_en`=1:
  - MSB_FIRST=1: `sr` becomes `{sr[WIDTH-2:0], s_in}`.
  - MSB_FIRST=0: `sr` becomes `{s_in, sr[WIDTH-1:1]}`.
  - `cnt` increments.
- **Word completion.** A capture with `cnt`==WIDTH-1 completes a word. The completed word is `sr` including the new bit; `cnt` wraps to 0.
- **`sync`.**
  - `sync`=1 with `s_en`=1: the current bit is bit 0 of a new word. Any partial word is discarded and `cnt` becomes 1.
  - `sync`=1 with `s_en`=0: `cnt` becomes 0 and the partial word is discarded.
  - `sync` never produces a word by itself.
- **Output state machine.**
  - EMPTY, word completes: `p_data` is loaded and the state goes to FULL.
  - FULL, with `p_ready`=1 and no completion: go to EMPTY.
  - FULL, with `p_ready`=1 and a completion on the same edge: load the new word and stay FULL. No bubble, no overrun.
  - FULL, with `p_ready`=0 and a completion: the new word is dropped, `p_data` is unchanged, and `overrun` becomes 1.
- **Overrun flag.** `overrun` stays set until `clr_ovr`=1 or `rst`. If `clr_ovr` and a new overrun occur on the same edge, the set wins.
- **`s_en`=0.** `sr` and `cnt` hold; the output state machine still honours `p_ready`.
- **Width rules.** `cnt` is compared against WIDTH-1 explicitly, so any WIDTH is legal, power of two or not. `sr` bits outside the current word are don't-care; only completed words are visible.

## Timing
- Reset values, asynchronous on `rst` rising:
  - `sr`=0, `cnt`=0, output state EMPTY;
  - `p_data`=0, `p_valid`=0, `overrun`=0.
- Reset applied mid-word discards the partial word and any held word. The first strobe after `rst` falls is bit 0.
- Latency: `p_valid` rises in the cycle after the edge that captured the last bit. Minimum word period is WIDTH cycles, one per strobe.
- With `s_en` held high and `p_ready` held high, a word is emitted every WIDTH cycles with no gaps.
- `p_data` changes only on an edge that loads a word; it never changes while FULL without a handshake.
- `p_ready` has no combinational path to any output; all outputs are registered.

## Structure
- Shared package/header `reg_pkg`, holding:
  - output-state encodings OUT_EMPTY=1'b0 and OUT_FULL=1'b1;
  - the default word width constant, shared with the parallel-load shifter so the two ends agree.
- Sub-module `sipo_bit_cnt`:
  - parameter WIDTH;
  - inputs `clk`, `rst`, `s_en`, `sync`;
  - outputs `cnt` and a one-cycle `last` pulse, high when the capturing edge completes a word.
- The shift register and output state machine stay in `reg_sipo_rx`.

## Test plan
- **Basic word.** WIDTH=4, MSB_FIRST=1, `p_ready`=1; strobe bits 1,0,1,1 on consecutive cycles.
  - `p_data`=4'hB, with `p_valid` high for exactly 1 cycle, the cycle after the 4th bit.
- **LSB-first.** MSB_FIRST=0, bits 1,0,1,1.
  - `p_data`=4'hD.
- **Stall and overrun.** `p_ready`=0; send 4'hA then 4'h5.
  - `p_data` stays 4'hA and `overrun`=1 after the 8th bit.
  - Raising `p_ready` consumes 4'hA.
  - `clr_ovr` pulse returns `overrun` to 0.
- **Back-to-back.** Continuous strobes of 4'h3, 4'hC, 4'h9, with `p_ready` pulsing on each completion edge.
  - Three words are delivered in order, `p_valid` stays high across the handshakes, and `overrun`=0.
- **Realignment.** Send bits 1,1; then assert `sync` with `s_en` and bit 0; then bits 1,1,0.
  - `p_data`=4'h6; the 2 leading bits are discarded.
- **Reset mid-operation.** Assert `rst` asynchronously, between edges, after 2 bits and with a held word 4'hF.
  - `p_valid`, `p_data` and `overrun` go to 0 immediately.
  - The next 4 bits 0,1,1,1 yield 4'h7.
